rv32m_muldiv_unit: RTL and testbench
====================================

Name: rv32m_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes its two read-port values as operands.
- Feeds the result, destination index and write strobe back to the register file's write port (WRITE_DATA3 / ADDRESS3 / REG_WRITE).
- One operation in flight; start/busy/done handshake lets the control path stall while the unit iterates.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- REG_AW, 5, register index width.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous active-low reset
- START  input  1  launch operation; sampled only in IDLE
- FUNCT3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OPERAND_A  input  32  rs1 value (register file READ_DATA1)
- OPERAND_B  input  32  rs2 value (register file READ_DATA2)
- RD_IN  input  5  destination register index
- BUSY  output  1  high while state != IDLE
- DONE  output  1  one-cycle completion pulse
- REG_WRITE  output  1  write strobe to register file; equals DONE && RD_OUT != 0
- RD_OUT  output  5  latched destination index
- RESULT  output  32  result, held until next accepted START

Behaviour:
- Reset: RST=0 at a rising edge forces state IDLE and clears BUSY, DONE, REG_WRITE, RD_OUT and RESULT to 0, plus all internal accumulators and counter. This applies mid-operation: the in-flight op is abandoned and no write is issued.
- States: IDLE -> CALC -> FIN -> IDLE.
- IDLE:
  - START=1 latches FUNCT3, OPERAND_A, OPERAND_B and RD_IN, loads the 6-bit counter with 32, and goes to CALC.
  - START=0 stays in IDLE.
- CALC: one iteration per cycle; counter decrements; at counter==1 the next state is FIN.
- FIN: RESULT is registered on entry; DONE=1 for exactly this cycle; next state is IDLE.
- Latency: START high in cycle 0 -> BUSY high in cycles 1..33, DONE/REG_WRITE high in cycle 33, BUSY low and unit ready in cycle 34.
- START while BUSY is ignored; no queueing. START in the same cycle DONE is high is also ignored.
- Multiply: radix-2 shift-add on 33-bit sign/zero-extended operands giving a 64-bit product.
  - Signedness: MUL/MULH both signed, MULHSU A signed / B unsigned, MULHU both unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide: restoring division on magnitudes.
  - Signed ops negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = OPERAND_A (unsigned and signed).
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Special cases still take the full 33-cycle latency unless the optional feature is enabled.
- RD_OUT==0: DONE still pulses, REG_WRITE stays 0.
- Inputs are captured at START; later changes on OPERAND_A/B/RD_IN do not affect the op in flight.

Optional Feature:
- Macro: RV32M_MULDIV_EARLY_EN.
- Defined: in IDLE, START with a divide by zero, signed overflow, or either multiply operand equal to 0 goes directly to FIN with the special/zero result. DONE is then high in cycle 1, BUSY high in cycle 1 only.
- Undefined: every op takes 33 cycles; no early-detection logic is synthesised.

Test Plan:
- MUL A=6, B=0x2004, RD_IN=7, START pulse in cycle 0 -> DONE=1, REG_WRITE=1, RESULT=0x0000C018, RD_OUT=7 in cycle 33; BUSY low in cycle 34.
- MULH A=0xFFFFFFFF, B=0xFFFFFFFF -> RESULT=0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> RESULT=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=0 -> 0xFFFFFFFF; REMU A=100, B=0 -> 100.
- DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000, REM -> 0. With RV32M_MULDIV_EARLY_EN this completes at cycle 1, otherwise at cycle 33.
- Second START asserted in cycle 5 with different operands -> ignored; result equals the first op; RD_IN=0 op -> DONE pulses, REG_WRITE stays 0.
- RST=0 in cycle 10 of a DIVU -> cycle 11: BUSY=0, RESULT=0, RD_OUT=0; no DONE or REG_WRITE pulse ever appears; a new START in cycle 12 completes normally.

Source files
------------

// File: rtl/rv32m_muldiv_unit_if.sv
// Operand/result bundle between the control path, register file ports and the RV32M mul/div unit.
interface rv32m_muldiv_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              START;
  logic [2:0]        FUNCT3;
  logic [XLEN-1:0]   OPERAND_A;
  logic [XLEN-1:0]   OPERAND_B;
  logic [REG_AW-1:0] RD_IN;
  logic              BUSY;
  logic              DONE;
  logic              REG_WRITE;
  logic [REG_AW-1:0] RD_OUT;
  logic [XLEN-1:0]   RESULT;

  modport master (
    output START, FUNCT3, OPERAND_A, OPERAND_B, RD_IN,
    input  BUSY, DONE, REG_WRITE, RD_OUT, RESULT
  );

  modport slave (
    input  START, FUNCT3, OPERAND_A, OPERAND_B, RD_IN,
    output BUSY, DONE, REG_WRITE, RD_OUT, RESULT
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Optional macro RV32M_MULDIV_EARLY_EN: zero-operand multiplies and divide special cases finish in one cycle.
module rv32m_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic                CLK,
  input logic                RST,
  rv32m_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   opa_q, opa_d;
  logic [XLEN:0]       opb_q, opb_d;
  logic [2:0]          f3_q, f3_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                div0_q, div0_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_q, wr_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic [2*XLEN-1:0]   mul_acc_s, prod_s;
  logic [XLEN:0]       div_diff_s;
  logic [2*XLEN-1:0]   div_acc_s, iter_acc_s;
  logic [XLEN-1:0]     quo_s, rem_s, final_res_s;

  function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] val);
    return cond ? (32'd0 - val) : val;
  endfunction

  // Operand signedness and divide magnitudes for the op being launched
  always_comb begin
    if (bus.FUNCT3[2]) begin
      a_sgn_s = ~bus.FUNCT3[0] & bus.OPERAND_A[31];
      b_sgn_s = ~bus.FUNCT3[0] & bus.OPERAND_B[31];
    end else begin
      a_sgn_s = (bus.FUNCT3[1:0] != 2'b11) & bus.OPERAND_A[31];
      b_sgn_s = ~bus.FUNCT3[1] & bus.OPERAND_B[31];
    end
    mag_a_s = neg_if(a_sgn_s, bus.OPERAND_A);
    mag_b_s = neg_if(b_sgn_s, bus.OPERAND_B);
  end

`ifdef RV32M_MULDIV_EARLY_EN
  logic            early_s;
  logic [XLEN-1:0] early_res_s;

  // Ops whose result is known without iterating
  always_comb begin
    early_s     = 1'b0;
    early_res_s = 32'd0;
    if (bus.FUNCT3[2]) begin
      if (bus.OPERAND_B == 32'd0) begin
        early_s     = 1'b1;
        early_res_s = bus.FUNCT3[1] ? bus.OPERAND_A : 32'hFFFF_FFFF;
      end else if (~bus.FUNCT3[0] && (bus.OPERAND_A == 32'h8000_0000) &&
                   (bus.OPERAND_B == 32'hFFFF_FFFF)) begin
        early_s     = 1'b1;
        early_res_s = bus.FUNCT3[1] ? 32'd0 : 32'h8000_0000;
      end else begin
        early_s     = 1'b0;
      end
    end else begin
      early_s = (bus.OPERAND_A == 32'd0) || (bus.OPERAND_B == 32'd0);
    end
  end
`endif

  // One multiply or divide step, plus the final result as it would look after that step.
  // opb bit 32 carries the multiplier sign weight -2^32, applied as a final subtraction.
  always_comb begin
    mul_acc_s  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    prod_s     = mul_acc_s - (opb_q[1] ? {opa_q[2*XLEN-2:0], 1'b0} : 64'd0);
    div_diff_s = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opa_q[XLEN-1:0]};
    if (div_diff_s[XLEN]) begin
      div_acc_s = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      div_acc_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    iter_acc_s = f3_q[2] ? div_acc_s : mul_acc_s;
    quo_s      = div0_q ? 32'hFFFF_FFFF : neg_if(qneg_q, div_acc_s[XLEN-1:0]);
    rem_s      = neg_if(rneg_q, div_acc_s[2*XLEN-1:XLEN]);
    if (f3_q[2]) begin
      final_res_s = f3_q[1] ? rem_s : quo_s;
    end else begin
      final_res_s = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          f3_d   = bus.FUNCT3;
          rd_d   = bus.RD_IN;
          cnt_d  = 6'd32;
          qneg_d = a_sgn_s ^ b_sgn_s;
          rneg_d = a_sgn_s;
          div0_d = (bus.OPERAND_B == 32'd0);
          if (bus.FUNCT3[2]) begin
            acc_d = {32'd0, mag_a_s};
            opa_d = {32'd0, mag_b_s};
            opb_d = 33'd0;
          end else begin
            acc_d = 64'd0;
            opa_d = {{32{a_sgn_s}}, bus.OPERAND_A};
            opb_d = {b_sgn_s, bus.OPERAND_B};
          end
`ifdef RV32M_MULDIV_EARLY_EN
          if (early_s) begin
            state_d  = S_FIN;
            result_d = early_res_s;
          end else begin
            state_d  = S_CALC;
          end
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - 6'd1;
        acc_d = iter_acc_s;
        if (!f3_q[2]) begin
          opa_d = {opa_q[2*XLEN-2:0], 1'b0};
          opb_d = {1'b0, opb_q[XLEN:1]};
        end else begin
          opa_d = opa_q;
        end
        if (cnt_q == 6'd1) begin
          state_d  = S_FIN;
          result_d = final_res_s;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    wr_d   = done_d && (rd_d != {REG_AW{1'b0}});
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      opa_q    <= 64'd0;
      opb_q    <= 33'd0;
      f3_q     <= 3'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= {REG_AW{1'b0}};
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      f3_q     <= f3_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.REG_WRITE = wr_q;
  assign bus.RD_OUT    = rd_q;
  assign bus.RESULT    = result_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed vectors with hand-computed results and completion cycles.
module tb_rv32m_muldiv_unit;

`ifdef RV32M_MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  rv32m_muldiv_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

  rv32m_muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    int          at;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          special;
    int          poke;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE/REG_WRITE must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.DONE === 1'b1 || bus.REG_WRITE === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got DONE=%b REG_WRITE=%b, expected none (cycle %0d)",
                 bus.DONE, bus.REG_WRITE, cyc);
      end else begin
        e = sb.pop_front();
        chk("done", {31'd0, bus.DONE}, 32'd1);
        chk("result", bus.RESULT, e.res);
        chk("rd_out", {27'd0, bus.RD_OUT}, {27'd0, e.rd});
        chk("reg_write", {31'd0, bus.REG_WRITE}, {31'd0, e.wr});
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic do_op(input vec_t v);
    exp_t e;
    int   c;
    int   lat;
    @(negedge clk);
    c   = cyc;
    lat = (v.special && EARLY) ? 1 : 33;
    bus.FUNCT3    = v.f3;
    bus.OPERAND_A = v.a;
    bus.OPERAND_B = v.b;
    bus.RD_IN     = v.rd;
    bus.START     = 1'b1;
    e.res = v.res;
    e.rd  = v.rd;
    e.wr  = (v.rd != 5'd0);
    e.at  = c + lat;
    sb.push_back(e);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.START = (v.poke != 0) && (k == v.poke);
      if (k == 1 || bus.START) begin
        bus.OPERAND_A = ~v.a;
        bus.OPERAND_B = v.b + 32'd3;
        bus.FUNCT3    = v.f3 ^ 3'b001;
        bus.RD_IN     = v.rd ^ 5'd1;
      end
      if (k == lat) chk({v.name, "_busy_at_done"}, {31'd0, bus.BUSY}, 32'd1);
      if (k > lat && sb.size() == 0) break;
    end
    bus.START = 1'b0;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no DONE, expected DONE at cycle %0d", v.name, e.at);
      sb.delete();
    end
    chk({v.name, "_busy_after"}, {31'd0, bus.BUSY}, 32'd0);
  endtask

  initial begin
    bus.START     = 1'b0;
    bus.FUNCT3    = 3'd0;
    bus.OPERAND_A = 32'd0;
    bus.OPERAND_B = 32'd0;
    bus.RD_IN     = 5'd0;

    vecs.push_back('{"mul",        3'b000, 32'h0000_0006, 32'h0000_2004, 5'd7,  32'h0000_C018, 1'b0, 0});
    vecs.push_back('{"mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0, 0});
    vecs.push_back('{"mulhu_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0, 0});
    vecs.push_back('{"mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0, 0});
    vecs.push_back('{"mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'h4000_0000, 1'b0, 0});
    vecs.push_back('{"mulhu_2",    3'b011, 32'h8000_0000, 32'h0000_0002, 5'd18, 32'h0000_0001, 1'b0, 0});
    vecs.push_back('{"mul_zero",   3'b000, 32'h1234_5678, 32'h0000_0000, 5'd15, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"div_neg",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 1'b0, 0});
    vecs.push_back('{"rem_neg",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 1'b0, 0});
    vecs.push_back('{"divu_zero",  3'b101, 32'h0000_0064, 32'h0000_0000, 5'd6,  32'hFFFF_FFFF, 1'b1, 0});
    vecs.push_back('{"remu_zero",  3'b111, 32'h0000_0064, 32'h0000_0000, 5'd8,  32'h0000_0064, 1'b1, 0});
    vecs.push_back('{"div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, 0});
    vecs.push_back('{"rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1'b1, 0});
    vecs.push_back('{"div_zero_s", 3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF, 1'b1, 0});
    vecs.push_back('{"rem_zero_s", 3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 5'd13, 32'hFFFF_FFF9, 1'b1, 0});
    vecs.push_back('{"remu_big",   3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 5'd19, 32'h0000_000F, 1'b0, 0});
    vecs.push_back('{"mul_rd0",    3'b000, 32'h0000_0003, 32'h0000_0005, 5'd0,  32'h0000_000F, 1'b0, 0});
    vecs.push_back('{"mul_poke5",  3'b000, 32'h0000_0007, 32'h0000_0009, 5'd16, 32'h0000_003F, 1'b0, 5});
    vecs.push_back('{"divu_poke",  3'b101, 32'h0000_03E8, 32'h0000_0007, 5'd17, 32'h0000_008E, 1'b0, 33});
    vecs.push_back('{"remu_7",     3'b111, 32'h0000_03E8, 32'h0000_0007, 5'd20, 32'h0000_0006, 1'b0, 0});

    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.BUSY},      32'd0);
    chk("rst_done",   {31'd0, bus.DONE},      32'd0);
    chk("rst_wr",     {31'd0, bus.REG_WRITE}, 32'd0);
    chk("rst_rd_out", {27'd0, bus.RD_OUT},    32'd0);
    chk("rst_result", bus.RESULT,             32'd0);
    rst = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // Reset in cycle 10 of a DIVU abandons it without any write
    @(negedge clk);
    bus.FUNCT3    = 3'b101;
    bus.OPERAND_A = 32'hFFFF_0000;
    bus.OPERAND_B = 32'h0000_0003;
    bus.RD_IN     = 5'd9;
    bus.START     = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.START = 1'b0;
      if (k == 10) rst = 1'b0;
    end
    @(negedge clk);
    chk("mid_rst_busy",   {31'd0, bus.BUSY},   32'd0);
    chk("mid_rst_done",   {31'd0, bus.DONE},   32'd0);
    chk("mid_rst_result", bus.RESULT,          32'd0);
    chk("mid_rst_rd_out", {27'd0, bus.RD_OUT}, 32'd0);
    rst = 1'b1;
    do_op('{"divu_after_rst", 3'b101, 32'hFFFF_0000, 32'h0000_0003, 5'd9, 32'h5555_0000, 1'b0, 0});

    repeat (40) @(negedge clk);
    chk("queue_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
